// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: width codes, AXI constants and FSM states shared by the cache and its AXI bridge
package cache_axi_pkg;
    localparam logic [2:0] WIDTH_BYTE = 3'b000;
    localparam logic [2:0] WIDTH_HALF = 3'b001;
    localparam logic [2:0] WIDTH_WORD = 3'b010;
    localparam logic [2:0] WIDTH_LINE = 3'b100;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LINE_LEN   = 8'd3;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

    function automatic logic [31:0] bus_addr(input logic [31:0] a, input logic [2:0] w);
        return w == WIDTH_LINE ? {a[31:4], 4'h0} : a;
    endfunction

    function automatic logic [7:0] bus_len(input logic [2:0] w);
        return w == WIDTH_LINE ? LINE_LEN : 8'd0;
    endfunction

    function automatic logic [2:0] bus_size(input logic [2:0] w);
        return w == WIDTH_LINE ? SIZE_WORD : {1'b0, w[1:0]};
    endfunction
endpackage

// File: rtl/cache_axi_bridge_if.sv
// cache_axi_bridge_if: AXI read/write channel bundle between the cache bridge and memory
interface cache_axi_bridge_if;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
               awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
        input  arready, rvalid, rdata, rlast, awready, wready, bvalid
    );
    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
               awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rdata, rlast, awready, wready, bvalid
    );
endinterface

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: turns cache load/store requests into AXI bursts with independent read and write FSMs
module cache_axi_bridge
    import cache_axi_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_LoadRequire,
    input  logic [2:0]          i_LoadWidth,
    input  logic [31:0]         i_LoadAddr,
    output logic                o_LoadReady,
    output logic                o_ReturnValid,
    output logic                o_ReturnLast,
    output logic [31:0]         o_ReturnData,
    input  logic                i_WriteRequire,
    input  logic [2:0]          i_WriteWidth,
    input  logic [31:0]         i_WriteAddr,
    input  logic [3:0]          i_WriteByteEnable,
    input  logic [127:0]        i_WriteData,
    output logic                o_WriteReady,
    cache_axi_bridge_if.master  m
);
    rd_state_t    rd_state;
    wr_state_t    wr_state;
    logic         wr_line;
    logic [3:0]   wr_strb;
    logic [127:0] wr_data;
    logic [1:0]   beat;
    logic         conflict;

    // a load may not overtake a pending or same-cycle write to the same line
    assign conflict = (wr_state != W_IDLE || i_WriteRequire) &&
                      i_LoadAddr[31:4] == (wr_state == W_IDLE ? i_WriteAddr[31:4] : m.awaddr[31:4]);
    assign o_LoadReady   = rd_state == R_IDLE && !conflict;
    assign o_WriteReady  = wr_state == W_IDLE;
    assign o_ReturnValid = m.rready && m.rvalid;
    assign o_ReturnLast  = o_ReturnValid && m.rlast;
    assign o_ReturnData  = m.rdata;
    assign m.arburst     = BURST_INCR;
    assign m.awburst     = BURST_INCR;
    assign m.wdata       = wr_data[{beat, 5'b0} +: 32];
    assign m.wstrb       = wr_line ? 4'hf : wr_strb;
    assign m.wlast       = !wr_line || beat == 2'd3;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_state  <= R_IDLE;
            m.arvalid <= 1'b0;
            m.rready  <= 1'b0;
            m.araddr  <= '0;
            m.arlen   <= '0;
            m.arsize  <= '0;
        end else begin
            case (rd_state)
                R_IDLE: if (i_LoadRequire && o_LoadReady) begin
                    rd_state  <= R_ADDR;
                    m.arvalid <= 1'b1;
                    m.araddr  <= bus_addr(i_LoadAddr, i_LoadWidth);
                    m.arlen   <= bus_len(i_LoadWidth);
                    m.arsize  <= bus_size(i_LoadWidth);
                end
                R_ADDR: if (m.arready) begin
                    rd_state  <= R_DATA;
                    m.arvalid <= 1'b0;
                    m.rready  <= 1'b1;
                end
                R_DATA: if (m.rvalid && m.rlast) begin
                    rd_state <= R_IDLE;
                    m.rready <= 1'b0;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_state  <= W_IDLE;
            m.awvalid <= 1'b0;
            m.wvalid  <= 1'b0;
            m.bready  <= 1'b0;
            m.awaddr  <= '0;
            m.awlen   <= '0;
            m.awsize  <= '0;
            wr_line   <= 1'b0;
            wr_strb   <= '0;
            wr_data   <= '0;
            beat      <= '0;
        end else begin
            case (wr_state)
                W_IDLE: if (i_WriteRequire) begin
                    wr_state  <= W_ADDR;
                    m.awvalid <= 1'b1;
                    m.awaddr  <= bus_addr(i_WriteAddr, i_WriteWidth);
                    m.awlen   <= bus_len(i_WriteWidth);
                    m.awsize  <= bus_size(i_WriteWidth);
                    wr_line   <= i_WriteWidth == WIDTH_LINE;
                    wr_strb   <= i_WriteByteEnable;
                    wr_data   <= i_WriteData;
                    beat      <= '0;
                end
                W_ADDR: if (m.awready) begin
                    wr_state  <= W_DATA;
                    m.awvalid <= 1'b0;
                    m.wvalid  <= 1'b1;
                end
                W_DATA: if (m.wready) begin
                    beat <= beat + 2'd1;
                    if (m.wlast) begin
                        wr_state <= W_RESP;
                        m.wvalid <= 1'b0;
                        m.bready <= 1'b1;
                    end
                end
                W_RESP: if (m.bvalid) begin
                    wr_state <= W_IDLE;
                    m.bready <= 1'b0;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: randomized and directed checks of the bridge against a transaction-level model
module tb_cache_axi_bridge;
    logic         clk = 1'b0;
    logic         rstn;
    logic         load_req, load_ready, ret_valid, ret_last;
    logic [2:0]   load_width;
    logic [31:0]  load_addr, ret_data;
    logic         wr_req, wr_ready;
    logic [2:0]   wr_width;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_be;
    logic [127:0] wr_data;
    int           checks = 0;
    int           errors = 0;
    bit           blocked = 0;

    cache_axi_bridge_if bus();

    cache_axi_bridge dut (
        .clk(clk), .rstn(rstn),
        .i_LoadRequire(load_req), .i_LoadWidth(load_width), .i_LoadAddr(load_addr),
        .o_LoadReady(load_ready), .o_ReturnValid(ret_valid), .o_ReturnLast(ret_last),
        .o_ReturnData(ret_data),
        .i_WriteRequire(wr_req), .i_WriteWidth(wr_width), .i_WriteAddr(wr_addr),
        .i_WriteByteEnable(wr_be), .i_WriteData(wr_data), .o_WriteReady(wr_ready),
        .m(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [2:0] w);
        return w == 3'b100 ? a - (a % 16) : a;
    endfunction

    function automatic int beats(input logic [2:0] w);
        return w == 3'b100 ? 4 : 1;
    endfunction

    task automatic accept_read(input logic [31:0] a, input logic [2:0] w);
        load_req = 1; load_addr = a; load_width = w;
        #1 check("load_ready", load_ready, 1);
        tick();
        load_req = 0;
    endtask

    task automatic finish_read(input logic [31:0] a, input logic [2:0] w, input int ar_delay);
        logic [31:0] d;
        for (int k = 0; k <= ar_delay; k++) begin
            bus.arready = (k == ar_delay);
            #1;
            check("arvalid", bus.arvalid, 1);
            check("araddr", bus.araddr, exp_addr(a, w));
            check("arlen", bus.arlen, beats(w) - 1);
            check("arsize", bus.arsize, w == 3'b100 ? 2 : w % 4);
            check("arburst", bus.arburst, 1);
            tick();
        end
        bus.arready = 0;
        #1 check("arvalid_drop", bus.arvalid, 0);
        check("rready", bus.rready, 1);
        for (int b = 0; b < beats(w); b++) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.rvalid = 0;
                #1 check("ret_valid_idle", ret_valid, 0);
                tick();
            end
            d = $urandom;
            bus.rvalid = 1; bus.rdata = d; bus.rlast = (b == beats(w) - 1);
            #1;
            check("ret_valid", ret_valid, 1);
            check("ret_data", ret_data, d);
            check("ret_last", ret_last, b == beats(w) - 1);
            tick();
        end
        bus.rvalid = 0; bus.rlast = 0;
        #1 check("rready_drop", bus.rready, 0);
    endtask

    task automatic accept_write(input logic [31:0] a, input logic [2:0] w, input logic [3:0] be,
                                input logic [127:0] d);
        wr_req = 1; wr_addr = a; wr_width = w; wr_be = be; wr_data = d;
        #1 check("write_ready", wr_ready, 1);
        tick();
        wr_req = 0;
        #1 check("write_busy", wr_ready, 0);
    endtask

    task automatic finish_write(input logic [31:0] a, input logic [2:0] w, input logic [3:0] be,
                                input logic [127:0] d, input int aw_delay, input bit toggle);
        int b = 0;
        int cyc = 0;
        for (int k = 0; k <= aw_delay; k++) begin
            bus.awready = (k == aw_delay);
            #1;
            check("awvalid", bus.awvalid, 1);
            check("awaddr", bus.awaddr, exp_addr(a, w));
            check("awlen", bus.awlen, beats(w) - 1);
            check("awsize", bus.awsize, w == 3'b100 ? 2 : w % 4);
            check("awburst", bus.awburst, 1);
            if (blocked) check("load_blocked_aw", load_ready, 0);
            tick();
        end
        bus.awready = 0;
        while (b < beats(w) && cyc < 40) begin
            bus.wready = toggle ? cyc[0] : 1'($urandom_range(0, 1));
            #1;
            check("wvalid", bus.wvalid, 1);
            check("wdata", bus.wdata, d[32*b +: 32]);
            check("wstrb", bus.wstrb, w == 3'b100 ? 4'hf : be);
            check("wlast", bus.wlast, b == beats(w) - 1);
            if (blocked) check("load_blocked_w", load_ready, 0);
            if (bus.wready) b++;
            tick();
            cyc++;
        end
        bus.wready = 0;
        check("w_beats", b, beats(w));
        #1 check("wvalid_drop", bus.wvalid, 0);
        check("bready", bus.bready, 1);
        repeat ($urandom_range(0, 2)) begin
            tick();
            check("bready_wait", bus.bready, 1);
        end
        bus.bvalid = 1;
        #1 if (blocked) check("load_blocked_b", load_ready, 0);
        tick();
        bus.bvalid = 0;
        #1 check("bready_drop", bus.bready, 0);
        check("write_idle", wr_ready, 1);
    endtask

    initial begin
        logic [2:0]   widths [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
        logic [2:0]   w;
        logic [31:0]  a;
        logic [127:0] d;
        rstn = 0; load_req = 0; load_width = 0; load_addr = 0;
        wr_req = 0; wr_width = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rlast = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        tick(); tick();
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_load_ready", load_ready, 1);
        check("rst_write_ready", wr_ready, 1);
        rstn = 1;
        tick();

        accept_read(32'h0000_1234, 3'b100);
        finish_read(32'h0000_1234, 3'b100, 2);
        check("line_read_idle", load_ready, 1);
        accept_read(32'h0000_0007, 3'b000);
        finish_read(32'h0000_0007, 3'b000, 0);
        check("byte_read_idle", load_ready, 1);

        d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        accept_write(32'h0000_2040, 3'b100, 4'h0, d);
        finish_write(32'h0000_2040, 3'b100, 4'h0, d, 1, 1);

        accept_write(32'h0000_3000, 3'b010, 4'h3, {96'h0, 32'hcafe_f00d});
        load_req = 1; load_addr = 32'h0000_3008; load_width = 3'b010;
        repeat (3) begin
            #1 check("raw_block", load_ready, 0);
            tick();
            check("raw_no_ar", bus.arvalid, 0);
        end
        blocked = 1;
        finish_write(32'h0000_3000, 3'b010, 4'h3, {96'h0, 32'hcafe_f00d}, 1, 0);
        blocked = 0;
        accept_read(32'h0000_3008, 3'b010);
        finish_read(32'h0000_3008, 3'b010, 1);

        accept_write(32'h0000_3000, 3'b001, 4'h1, {96'h0, 32'h1234_5678});
        accept_read(32'h0000_4000, 3'b010);
        finish_read(32'h0000_4000, 3'b010, 0);
        finish_write(32'h0000_3000, 3'b001, 4'h1, {96'h0, 32'h1234_5678}, 0, 0);

        d = {$urandom, $urandom, $urandom, $urandom};
        wr_req = 1; wr_addr = 32'h0000_5000; wr_width = 3'b100; wr_be = 4'h5; wr_data = d;
        load_req = 1; load_addr = 32'h0000_6010; load_width = 3'b100;
        #1 check("dual_load_ready", load_ready, 1);
        check("dual_write_ready", wr_ready, 1);
        tick();
        wr_req = 0; load_req = 0;
        finish_read(32'h0000_6010, 3'b100, 1);
        finish_write(32'h0000_5000, 3'b100, 4'h5, d, 2, 0);

        wr_req = 1; wr_addr = 32'h0000_7000; wr_width = 3'b100; wr_data = d;
        load_req = 1; load_addr = 32'h0000_7004; load_width = 3'b010;
        #1 check("same_line_load", load_ready, 0);
        check("same_line_write", wr_ready, 1);
        tick();
        wr_req = 0; load_req = 0;
        #1 check("same_line_no_ar", bus.arvalid, 0);
        finish_write(32'h0000_7000, 3'b100, 4'h5, d, 0, 0);

        accept_read(32'h0000_8000, 3'b100);
        bus.arready = 1;
        tick();
        bus.arready = 0;
        bus.rvalid = 1; bus.rdata = 32'hd0; bus.rlast = 0;
        tick();
        bus.rdata = 32'hd1; rstn = 0;
        tick();
        rstn = 1;
        #1 check("rst_mid_rready", bus.rready, 0);
        check("rst_mid_ret_valid", ret_valid, 0);
        check("rst_mid_load_ready", load_ready, 1);
        bus.rvalid = 0;
        tick();

        for (int i = 0; i < 40; i++) begin
            w = widths[$urandom_range(0, 3)];
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                accept_read(a, w);
                finish_read(a, w, $urandom_range(0, 3));
                check("rand_read_idle", load_ready, 1);
            end else begin
                d = {$urandom, $urandom, $urandom, $urandom};
                accept_write(a, w, 4'($urandom_range(0, 15)), d);
                finish_write(a, w, wr_be, d, $urandom_range(0, 3), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
